// File: rtl/tm1638_spi_rx.sv
// rtl/tm1638_spi_rx.sv - TM1638 3-wire serial receiver (display-controller end of the link)
// Optional input glitch filter: define TM1638_SPI_RX_GLITCH_FILTER_EN.
module tm1638_spi_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_BYTES   = 17
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_SPI_Stb,
  input  logic       i_SPI_Clk,
  input  logic       i_SPI_Dio,
  output logic [7:0] o_Data,
  output logic       o_Data_Valid,
  output logic       o_Data_First,
  input  logic       i_Data_Ack,
  output logic       o_Frame_End,
  output logic       o_Error,
  output logic       o_Overrun,
  output logic [1:0] o_Diag_State,
  output logic [4:0] o_Diag_Count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    DATA    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  localparam logic [4:0] MAX_CNT = 5'(MAX_BYTES);

  state_t                 state;
  logic [SYNC_STAGES-1:0] stb_sync;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dio_sync;
  logic                   stb_s;
  logic                   clk_s;
  logic                   dio_s;
  logic                   stb_q;
  logic                   clk_q;
  logic                   clk_rise;
  logic                   stb_rise;
  logic                   stb_fall;
  logic [7:0]             shift;
  logic [2:0]             bit_cnt;
  logic [4:0]             byte_cnt;
  logic                   load_pend;
  logic                   pend_first;

  // Preset to 1 so a reset never fabricates a bus edge.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      stb_sync <= '1;
      clk_sync <= '1;
      dio_sync <= '1;
    end else begin
      stb_sync <= {stb_sync[SYNC_STAGES-2:0], i_SPI_Stb};
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], i_SPI_Clk};
      dio_sync <= {dio_sync[SYNC_STAGES-2:0], i_SPI_Dio};
    end
  end

`ifdef TM1638_SPI_RX_GLITCH_FILTER_EN
  logic stb_f;
  logic clk_f;
  logic dio_f;

  // The last two synchroniser stages are consecutive samples; update only when they agree.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      stb_f <= 1'b1;
      clk_f <= 1'b1;
      dio_f <= 1'b1;
    end else begin
      if (stb_sync[SYNC_STAGES-1] == stb_sync[SYNC_STAGES-2]) stb_f <= stb_sync[SYNC_STAGES-1];
      if (clk_sync[SYNC_STAGES-1] == clk_sync[SYNC_STAGES-2]) clk_f <= clk_sync[SYNC_STAGES-1];
      if (dio_sync[SYNC_STAGES-1] == dio_sync[SYNC_STAGES-2]) dio_f <= dio_sync[SYNC_STAGES-1];
    end
  end

  assign stb_s = stb_f;
  assign clk_s = clk_f;
  assign dio_s = dio_f;
`else
  assign stb_s = stb_sync[SYNC_STAGES-1];
  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dio_s = dio_sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      stb_q <= 1'b1;
      clk_q <= 1'b1;
    end else begin
      stb_q <= stb_s;
      clk_q <= clk_s;
    end
  end

  assign clk_rise = clk_s & ~clk_q;
  assign stb_rise = stb_s & ~stb_q;
  assign stb_fall = ~stb_s & stb_q;

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state        <= IDLE;
      shift        <= 8'd0;
      bit_cnt      <= 3'd0;
      byte_cnt     <= 5'd0;
      load_pend    <= 1'b0;
      pend_first   <= 1'b0;
      o_Data       <= 8'd0;
      o_Data_Valid <= 1'b0;
      o_Data_First <= 1'b0;
      o_Frame_End  <= 1'b0;
      o_Error      <= 1'b0;
      o_Overrun    <= 1'b0;
    end else begin
      o_Frame_End <= 1'b0;
      o_Error     <= 1'b0;
      o_Overrun   <= 1'b0;
      load_pend   <= 1'b0;

      if (o_Data_Valid && i_Data_Ack) o_Data_Valid <= 1'b0;

      // A completed byte lands one cycle after its 8th bit; an ack in this cycle frees the slot.
      if (load_pend) begin
        o_Data       <= shift;
        o_Data_First <= pend_first;
        o_Data_Valid <= 1'b1;
        o_Overrun    <= o_Data_Valid && !i_Data_Ack;
      end

      case (state)
        IDLE: begin
          if (stb_fall) begin
            state    <= CMD;
            bit_cnt  <= 3'd0;
            byte_cnt <= 5'd0;
            shift    <= 8'd0;
          end
        end
        CMD, DATA: begin
          if (stb_rise) begin
            o_Frame_End <= 1'b1;
            o_Error     <= (bit_cnt != 3'd0);
            bit_cnt     <= 3'd0;
            state       <= IDLE;
          end else if (clk_rise) begin
            if (byte_cnt == MAX_CNT) begin
              o_Error <= 1'b1;
              state   <= DISCARD;
            end else begin
              shift[bit_cnt] <= dio_s;
              bit_cnt        <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                byte_cnt   <= byte_cnt + 5'd1;
                load_pend  <= 1'b1;
                pend_first <= (state == CMD);
                state      <= DATA;
              end
            end
          end
        end
        DISCARD: begin
          if (stb_rise) begin
            o_Frame_End <= 1'b1;
            o_Error     <= (bit_cnt != 3'd0);
            bit_cnt     <= 3'd0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_Diag_State = state;
  assign o_Diag_Count = byte_cnt;

endmodule

// File: doc/tm1638_spi_rx.md
Name: tm1638_spi_rx

Overview:
- Receive-side counterpart of the TM1638 3-wire serial transmitter; behaves as the display-controller end of the link.
- Samples STB/CLK/DIO from the bus, deserialises bytes LSB-first and tags the first byte of each frame as the command byte.
- Presents each byte on a valid/ack handshake; detects truncated bytes, frame overflow and consumer overrun.
- Used as a loopback checker and display-controller model in the FPGA build.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of each input synchroniser (minimum 2).
- MAX_BYTES, 17, maximum bytes per frame: 1 command + 16 data.

Ports:
- i_Clk  in  1  system clock; every flop on its rising edge.
- i_Rst  in  1  asynchronous, active-low reset.
- i_SPI_Stb  in  1  frame strobe, active low, asynchronous to i_Clk.
- i_SPI_Clk  in  1  serial clock; idles high; data sampled on its rising edge.
- i_SPI_Dio  in  1  serial data, LSB first.
- o_Data  out  8  last complete byte.
- o_Data_Valid  out  1  o_Data holds an unacknowledged byte.
- o_Data_First  out  1  qualifies o_Data: 1 = command byte, 0 = data byte.
- i_Data_Ack  in  1  consumer takes the byte when high together with o_Data_Valid.
- o_Frame_End  out  1  one-cycle pulse when STB returns high after an active frame.
- o_Error  out  1  one-cycle pulse: truncated byte or frame overflow.
- o_Overrun  out  1  one-cycle pulse: a new byte overwrote an unacknowledged byte.
- o_Diag_State  out  2  current FSM state encoding.
- o_Diag_Count  out  5  bytes completed in the current frame.

Behaviour:
- Reset (i_Rst low, asynchronous): all outputs 0; shift register, bit counter and byte counter 0; all synchronisers preset to 1 (bus idle); state IDLE.
- Synchronisers: STB, CLK and DIO each pass through SYNC_STAGES flops. A CLK rise is the synchronised CLK going from 0 to 1. DIO is taken from the same synchroniser stage as CLK.
- State encodings: IDLE=0, CMD=1, DATA=2, DISCARD=3.
- IDLE: synchronised STB falling -> CMD; bit count 0, byte count 0.
- CMD and DATA, on each CLK rise:
  - shift DIO into bit [bit count], LSB first; increment bit count.
  - on the 8th bit, the next cycle sets o_Data, o_Data_Valid=1, and o_Data_First=1 in CMD or 0 in DATA; byte count increments; bit count clears.
  - CMD -> DATA after the first byte.
- Byte-valid latency: SYNC_STAGES+2 i_Clk cycles after the 8th pin-level CLK rise, with +1 cycle of uncertainty from asynchronous sampling.
- Overflow: on a CLK rise with byte count == MAX_BYTES -> pulse o_Error, go to DISCARD. DISCARD ignores CLK until STB rises.
- STB rise in CMD, DATA or DISCARD -> pulse o_Frame_End, go to IDLE. If bit count != 0, pulse o_Error in the same cycle and discard the partial byte.
- STB rise in IDLE is ignored.
- Handshake: o_Data_Valid clears the cycle after i_Data_Ack is sampled high. i_Data_Ack with o_Data_Valid low has no effect.
- New byte completing while o_Data_Valid=1: the new byte overwrites o_Data and o_Data_First; o_Data_Valid stays 1; o_Overrun pulses.
- New byte completing in the same cycle as an ack of the old byte: the ack consumes the old byte; the new byte loads with o_Data_Valid=1; no overrun.
- STB falling in IDLE coinciding with a CLK rise: the CLK rise is ignored.
- CLK rises while STB is high are ignored entirely.
- o_Diag_Count saturates at MAX_BYTES.

Optional Feature:
- Macro: TM1638_SPI_RX_GLITCH_FILTER_EN.
- Defined: one extra flop stage per input. A level change is accepted only after two consecutive equal samples, so a single-cycle glitch on CLK or STB is rejected. Byte-valid latency increases by 1 cycle.
- Undefined: no filter; every synchronised transition is acted on.

Test Plan:
- Frame 0x40 at bus period 8 i_Clk, STB high afterwards -> one byte 0x40 with First=1, then Frame_End pulse; Error=0, Overrun=0.
- Frame 0xC0 0x3F 0x06, Ack held high -> bytes 0xC0/First=1, 0x3F/First=0, 0x06/First=0 in order; Diag_Count reaches 3; Frame_End pulses.
- STB raised after 5 bits of the second byte -> Error and Frame_End pulse in the same cycle; only the first byte is delivered; next frame 0x44 is received cleanly.
- 18 bytes in one frame with MAX_BYTES=17 -> 17 bytes delivered, Error pulses once on the 18th byte's first CLK rise, Diag_State=3 until STB rises.
- Ack held low across bytes 0x11 and 0x22 -> Overrun pulses once, o_Data=0x22, Valid stays 1 until Ack.
- Reset asserted mid-byte, then released, then frame 0x8F -> outputs 0 during reset; 0x8F received with First=1 and no stale bits. With the macro defined, a 1-cycle CLK glitch mid-byte is rejected.
